// File: rtl/ps2_mouse_pkt_if.sv
// ps2_mouse_pkt_if: wrapper-side byte handshake plus decoded mouse packet outputs
interface ps2_mouse_pkt_if;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] din;
  logic       init_done;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic       m_done_tick;
  modport master (
    output rx_done_tick, dout, tx_done_tick,
    input  wr_ps2, din, init_done, xm, ym, btnm, m_done_tick
  );
  modport slave (
    input  rx_done_tick, dout, tx_done_tick,
    output wr_ps2, din, init_done, xm, ym, btnm, m_done_tick
  );
endinterface

// File: rtl/ps2_mouse_pkt.sv
// ps2_mouse_pkt: enables mouse reporting, then decodes 3-byte packets into xm/ym/btnm (ports: clk, reset, m = slave side of ps2_mouse_pkt_if)
module ps2_mouse_pkt #(
  parameter logic [7:0] INIT_CMD    = 8'hF4,
  parameter logic [7:0] ACK_BYTE    = 8'hFA,
  parameter int         ACK_TIMEOUT = 5000000,
  parameter int         TW          = 23
) (
  input logic          clk,
  input logic          reset,
  ps2_mouse_pkt_if.slave m
);
  typedef enum logic [2:0] {INIT_SEND, INIT_TX, INIT_ACK, PACK1, PACK2, PACK3, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_inc;
  logic [7:0] b1, b2;
  logic tmo, ack, hdr, last;
  logic       wr_q, init_q, tick_q;
  logic [7:0] din_q;
  logic [8:0] xm_q, ym_q;
  logic [2:0] btn_q;
  assign cnt_inc = cnt + TW'(1);
  // retry fires on the edge where the counter would step onto ACK_TIMEOUT-1, so that
  // SEND plus the TX/ACK wait spans exactly ACK_TIMEOUT cycles between wr_ps2 pulses
  assign tmo  = cnt_inc == TW'(ACK_TIMEOUT - 1);
  assign ack  = state == INIT_ACK && m.rx_done_tick && m.dout == ACK_BYTE;
  assign hdr  = state == PACK1 && m.rx_done_tick && m.dout[3];
  assign last = state == PACK3 && m.rx_done_tick;
  always_comb begin
    state_n = state;
    case (state)
      INIT_SEND: state_n = INIT_TX;
      INIT_TX:   state_n = m.tx_done_tick ? INIT_ACK : tmo ? INIT_SEND : INIT_TX;
      INIT_ACK:  state_n = ack ? PACK1 : tmo ? INIT_SEND : INIT_ACK;
      PACK1:     state_n = hdr ? PACK2 : PACK1;
      PACK2:     state_n = m.rx_done_tick ? PACK3 : PACK2;
      PACK3:     state_n = m.rx_done_tick ? DONE : PACK3;
      DONE:      state_n = PACK1;
      default:   state_n = INIT_SEND;
    endcase
  end
  // outputs load on the edge that takes the third byte, so they are visible during DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= INIT_SEND;
      cnt    <= '0;
      b1     <= '0;
      b2     <= '0;
      wr_q   <= 1'b0;
      din_q  <= INIT_CMD;
      init_q <= 1'b0;
      tick_q <= 1'b0;
      xm_q   <= '0;
      ym_q   <= '0;
      btn_q  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= (state == INIT_TX || state == INIT_ACK) ? cnt_inc : '0;
      wr_q   <= state == INIT_SEND;
      din_q  <= INIT_CMD;
      init_q <= init_q | ack;
      tick_q <= last;
      if (hdr) b1 <= m.dout;
      if (state == PACK2 && m.rx_done_tick) b2 <= m.dout;
      if (last) begin
        xm_q  <= {b1[4], b2};
        ym_q  <= {b1[5], m.dout};
        btn_q <= b1[2:0];
      end
    end
  end
  assign m.wr_ps2      = wr_q;
  assign m.din         = din_q;
  assign m.init_done   = init_q;
  assign m.m_done_tick = tick_q;
  assign m.xm          = xm_q;
  assign m.ym          = ym_q;
  assign m.btnm        = btn_q;
endmodule

// File: tb/tb_ps2_mouse_pkt.sv
// tb_ps2_mouse_pkt: directed self-checking bench for ps2_mouse_pkt with a short ack timeout
module tb_ps2_mouse_pkt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int ticks = 0;
  int cyc, t0;
  ps2_mouse_pkt_if m ();
  ps2_mouse_pkt #(.ACK_TIMEOUT(20), .TW(8)) dut (.clk(clk), .reset(reset), .m(m));
  always #5 clk = ~clk;
  always @(posedge clk) if (m.m_done_tick) ticks++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rx(input logic [7:0] b);
    m.rx_done_tick = 1'b1;
    m.dout = b;
    step();
    m.rx_done_tick = 1'b0;
    m.dout = 8'h00;
  endtask
  task automatic tx();
    m.tx_done_tick = 1'b1;
    step();
    m.tx_done_tick = 1'b0;
  endtask
  task automatic outs(input string tag, input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    check({tag, "_xm"}, 32'(m.xm), 32'(x));
    check({tag, "_ym"}, 32'(m.ym), 32'(y));
    check({tag, "_btn"}, 32'(m.btnm), 32'(b));
  endtask
  initial begin
    m.rx_done_tick = 1'b0;
    m.tx_done_tick = 1'b0;
    m.dout = 8'h00;
    repeat (3) step();
    check("rst_wr", 32'(m.wr_ps2), 0);
    check("rst_din", 32'(m.din), 32'h0F4);
    check("rst_init", 32'(m.init_done), 0);
    check("rst_tick", 32'(m.m_done_tick), 0);
    outs("rst", 9'h000, 9'h000, 3'b000);
    reset = 1'b0;
    step();
    check("wr_first", 32'(m.wr_ps2), 1);
    check("din_first", 32'(m.din), 32'h0F4);
    step();
    check("wr_one_cycle", 32'(m.wr_ps2), 0);
    tx();
    rx(8'hFE);
    check("nak_ignored", 32'(m.init_done), 0);
    rx(8'hFA);
    check("init_done", 32'(m.init_done), 1);
    rx(8'h19);
    check("p1_b1_tick", 32'(m.m_done_tick), 0);
    rx(8'h05);
    check("p1_b2_tick", 32'(m.m_done_tick), 0);
    rx(8'hFE);
    check("p1_tick", 32'(m.m_done_tick), 1);
    outs("p1", 9'h105, 9'h0FE, 3'b001);
    step();
    check("p1_tick_end", 32'(m.m_done_tick), 0);
    outs("p1_hold", 9'h105, 9'h0FE, 3'b001);
    t0 = ticks;
    rx(8'h05);
    step();
    check("stray_tick", 32'(m.m_done_tick), 0);
    rx(8'h28);
    rx(8'h10);
    step();
    rx(8'h20);
    check("p2_tick", 32'(m.m_done_tick), 1);
    outs("p2", 9'h010, 9'h120, 3'b000);
    step();
    check("p2_tick_count", 32'(ticks - t0), 1);
    t0 = ticks;
    rx(8'h19);
    rx(8'h05);
    reset = 1'b1;
    step();
    check("mid_rst_init", 32'(m.init_done), 0);
    check("mid_rst_tick", 32'(m.m_done_tick), 0);
    outs("mid_rst", 9'h000, 9'h000, 3'b000);
    reset = 1'b0;
    step();
    check("wr_after_rst", 32'(m.wr_ps2), 1);
    cyc = 0;
    tx();
    cyc++;
    while (!m.wr_ps2 && cyc < 40) begin
      step();
      cyc++;
    end
    check("retry_spacing", 32'(cyc), 20);
    check("retry_no_init", 32'(m.init_done), 0);
    rx(8'hFE);
    tx();
    rx(8'hFA);
    check("late_ack_init", 32'(m.init_done), 1);
    check("partial_no_tick", 32'(ticks - t0), 0);
    rx(8'h3F);
    rx(8'hFF);
    rx(8'h80);
    check("p3_tick", 32'(m.m_done_tick), 1);
    outs("p3", 9'h1FF, 9'h180, 3'b111);
    step();
    check("p3_tick_count", 32'(ticks - t0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_pkt.md
Name: ps2_mouse_pkt

Overview:
Protocol layer that sits directly downstream of the PS2 tx/rx wrapper in the mouse path. After reset it sends the "enable data reporting" command (0xF4) through the wrapper's transmit side and waits for the mouse's acknowledge (0xFA). It then assembles the mouse's 3-byte stream packets into signed 9-bit X/Y movement values and a 3-bit button state. Each completed packet is signalled to the display/cursor logic with a one-cycle tick.

Parameters:
INIT_CMD, 8'hF4, command byte sent to the mouse after reset or retry
ACK_BYTE, 8'hFA, byte expected from the mouse as the acknowledge
ACK_TIMEOUT, 5000000, clock cycles allowed in INIT_TX plus INIT_ACK before re-sending INIT_CMD
TW, 23, timeout counter width; must satisfy 2^TW > ACK_TIMEOUT

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
rx_done_tick  input  1  one-cycle pulse from the wrapper: dout holds a new received byte
dout  input  8  received byte; valid only in the cycle rx_done_tick=1
tx_done_tick  input  1  one-cycle pulse from the wrapper: transmission of din is complete
wr_ps2  output  1  one-cycle request to the wrapper to transmit din
din  output  8  byte to transmit
init_done  output  1  high once ACK_BYTE has been received; stays high until reset
xm  output  9  X movement, two's complement: {byte1[4], byte2}
ym  output  9  Y movement, two's complement: {byte1[5], byte3}
btnm  output  3  buttons: byte1[2:0] = {middle, right, left}
m_done_tick  output  1  one-cycle pulse: xm, ym and btnm updated

Behaviour:
- Reset values: state = INIT_SEND, wr_ps2 = 0, din = INIT_CMD, init_done = 0, xm = 0, ym = 0, btnm = 0, m_done_tick = 0, timeout counter = 0, internal byte registers = 0.
- din and all outputs are registered. din is constant INIT_CMD.
- FSM states:
  - INIT_SEND:
    - wr_ps2 = 1 for exactly one cycle.
    - Clear the timeout counter.
    - Go to INIT_TX.
  - INIT_TX:
    - Wait for tx_done_tick, then go to INIT_ACK.
    - The timeout counter increments every cycle.
    - When the counter reaches ACK_TIMEOUT-1 without tx_done_tick, go to INIT_SEND.
  - INIT_ACK (the counter continues counting):
    - rx_done_tick with dout = ACK_BYTE: set init_done = 1 and go to PACK1.
    - rx_done_tick with any other byte: byte ignored, stay in INIT_ACK.
    - Counter reaches ACK_TIMEOUT-1: go to INIT_SEND (retry, unlimited count).
  - PACK1:
    - rx_done_tick with dout[3] = 1: latch byte1 and go to PACK2.
    - rx_done_tick with dout[3] = 0: discard the byte and stay in PACK1 (resynchronisation).
  - PACK2: rx_done_tick latches byte2, go to PACK3.
  - PACK3: rx_done_tick latches byte3, go to DONE.
  - DONE (one cycle):
    - xm, ym and btnm load from the latched bytes.
    - m_done_tick = 1 in this same cycle.
    - Go to PACK1.
- Latency: m_done_tick and the new xm/ym/btnm appear exactly 1 cycle after the third byte's rx_done_tick.
- xm, ym and btnm hold their values between packets. Overflow bits byte1[7:6] are ignored.
- Events ignored by state:
  - rx_done_tick in INIT_SEND or INIT_TX is ignored.
  - tx_done_tick outside INIT_TX is ignored.
  - rx_done_tick in DONE is lost. The wrapper's byte spacing (≥ about 1 ms) makes this impossible in practice.
- Timeout boundary: if tx_done_tick or the ACK arrives in the same cycle the counter reaches ACK_TIMEOUT-1, the handshake event wins.
- Reset asserted in any state, including mid-packet or mid-transmit:
  - Next cycle state = INIT_SEND.
  - All outputs take their reset values; the partial packet is discarded.
  - The sequence restarts with a new wr_ps2 pulse on the first cycle after reset deasserts.

Test Plan:
- Release reset → wr_ps2 = 1 for exactly 1 cycle with din = 0xF4 on the first post-reset cycle; init_done = 0, xm = ym = 0, btnm = 0.
- tx_done_tick, then rx_done_tick with dout = 0xFE, then rx_done_tick with dout = 0xFA → 0xFE ignored; init_done rises the cycle after 0xFA.
- After init, bytes 0x19, 0x05, 0xFE → one cycle after the third byte: m_done_tick = 1, xm = 9'h105, ym = 9'h0FE, btnm = 3'b001; values hold afterwards.
- After init, stray byte 0x05 (bit3 = 0), then 0x28, 0x10, 0x20 → no tick for 0x05; then xm = 9'h010, ym = 9'h120, btnm = 3'b000, exactly one m_done_tick.
- ACK_TIMEOUT = 20, tx_done_tick given, no ACK → second wr_ps2 pulse exactly 20 cycles after the first; late 0xFA then sets init_done.
- Reset asserted after bytes 1 and 2 of a packet → outputs return to 0 and wr_ps2 pulses again after reset deasserts; the old partial packet never produces m_done_tick.
